spi_flash_reader: RTL and testbench

Parametrised SPI NOR flash block reader; next generation of the single-mode 24-bit block read controller. Issues a read command to an external SPI flash and streams the returned bytes into a BRAM write port, one strobe per byte. Adds selectable 3/4-byte addressing, a per-request length, a busy flag, and an optional fast-read path with dummy cycles. Sits between the boot/loader logic and the board SPI flash pins.

---
 rtl/spi_flash_reader_if.sv | 39 +++
 rtl/spi_flash_reader.sv | 209 ++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: groups the request/completion handshake, the BRAM
// write port and the SPI flash pins of spi_flash_reader.
//   slave  modport - the reader itself (takes requests, drives BRAM and SPI).
//   master modport - the loader/flash side (issues requests, returns MISO).
// Signals:
//   i_read_addr[31:0]           flash byte start address
//   i_read_len[BRAM_AW:0]       byte count (0 or >BLOCK_SIZE = BLOCK_SIZE)
//   i_read_stb                  one-cycle request strobe
//   o_busy, o_read_done_stb     status / completion pulse
//   o_write_bram_stb/addr/data  one strobe per received byte
//   o_spi_cs_n, o_spi_clk, o_spi_mosi, i_spi_miso  SPI mode 3 pins
interface spi_flash_reader_if #(
  parameter int BRAM_AW = 10
);
  logic [31:0]        i_read_addr;
  logic [BRAM_AW:0]   i_read_len;
  logic               i_read_stb;
  logic               o_busy;
  logic               o_read_done_stb;
  logic               o_write_bram_stb;
  logic [BRAM_AW-1:0] o_write_bram_addr;
  logic [7:0]         o_write_bram_data;
  logic               o_spi_cs_n;
  logic               o_spi_clk;
  logic               o_spi_mosi;
  logic               i_spi_miso;

  modport slave (
    input  i_read_addr, i_read_len, i_read_stb, i_spi_miso,
    output o_busy, o_read_done_stb, o_write_bram_stb, o_write_bram_addr,
           o_write_bram_data, o_spi_cs_n, o_spi_clk, o_spi_mosi
  );

  modport master (
    output i_read_addr, i_read_len, i_read_stb, i_spi_miso,
    input  o_busy, o_read_done_stb, o_write_bram_stb, o_write_bram_addr,
           o_write_bram_data, o_spi_cs_n, o_spi_clk, o_spi_mosi
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI NOR flash block reader. Sends a read opcode and a
// 3- or 4-byte address (SPI mode 3), then shifts in the requested number of
// bytes and presents each one on a BRAM write strobe.
// Ports:
//   i_clk  system clock (rising edge)
//   i_rst  asynchronous active-high reset
//   bus    spi_flash_reader_if.slave (request handshake, BRAM port, SPI pins)
// Parameters: BLOCK_SIZE, BRAM_AW, ADDR_BYTES (3/4), SPI_CLK_DIV (half-period).
// Optional feature: define SPI_FLASH_FAST_READ_EN for fast-read opcodes
// (0x0B / 0x0C) with 8 dummy clocks between address and data.
module spi_flash_reader #(
  parameter int BLOCK_SIZE  = 512,
  parameter int BRAM_AW     = 10,
  parameter int ADDR_BYTES  = 3,
  parameter int SPI_CLK_DIV = 50
) (
  input logic               i_clk,
  input logic               i_rst,
  spi_flash_reader_if.slave bus
);
  localparam int LEN_W = BRAM_AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [7:0] OPCODE  = (ADDR_BYTES == 4) ? 8'h0C : 8'h0B;
`else
  localparam logic [7:0] OPCODE  = (ADDR_BYTES == 4) ? 8'h13 : 8'h03;
`endif
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  localparam logic [7:0]       DIV_LAST  = 8'(SPI_CLK_DIV - 1);
  localparam logic [5:0]       ADDR_LAST = 6'(8 * ADDR_BYTES - 1);
  localparam logic [LEN_W-1:0] BLK_LEN   = LEN_W'(BLOCK_SIZE);

  logic [2:0]         state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wstb_q, wstb_d;
  logic [BRAM_AW-1:0] waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [39:0]        tx_q, tx_d;        // opcode + address, MSB shifted first
  logic [6:0]         rx_q, rx_d;        // first 7 bits of the byte in flight
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               tick, fall, rise, shifting, hdr_phase;
  logic [LEN_W-1:0]   eff_len;

  assign tick = (div_q == DIV_LAST);
  // sclk idles high, so a wrap while high is a falling edge and vice versa
  assign fall = tick & sclk_q;
  assign rise = tick & ~sclk_q;
  assign hdr_phase = (state_q == S_CMD) || (state_q == S_ADDR);
  assign shifting  = hdr_phase || (state_q == S_DATA)
`ifdef SPI_FLASH_FAST_READ_EN
                     || (state_q == S_DUMMY)
`endif
                     ;
  assign eff_len = (bus.i_read_len == '0 || bus.i_read_len > BLK_LEN) ?
                   BLK_LEN : bus.i_read_len;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wstb_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;

    if (state_q == S_IDLE) begin
      div_d = '0;
      // busy stays up through the done cycle, so the earliest new request
      // is the cycle after the done pulse
      if (done_q) busy_d = 1'b0;
      if (!busy_q && bus.i_read_stb) begin
        busy_d     = 1'b1;
        cs_n_d     = 1'b0;
        state_d    = S_CMD;
        len_d      = eff_len;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        tx_d       = (ADDR_BYTES == 4) ? {OPCODE, bus.i_read_addr}
                                       : {OPCODE, bus.i_read_addr[23:0], 8'hFF};
      end
    end else if (state_q == S_END) begin
      // sclk already high after the last rising edge; wait one half-period
      div_d = tick ? '0 : div_q + 8'd1;
      if (tick) begin
        cs_n_d  = 1'b1;
        mosi_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end else if (shifting) begin
      div_d = tick ? '0 : div_q + 8'd1;
      if (fall) begin
        sclk_d = 1'b0;
        mosi_d = hdr_phase ? tx_q[39] : 1'b1;
        tx_d   = {tx_q[38:0], 1'b0};
      end
      if (rise) begin
        sclk_d    = 1'b1;
        bit_cnt_d = bit_cnt_q + 6'd1;
        case (state_q)
          S_CMD: if (bit_cnt_q == 6'd7) begin
            bit_cnt_d = '0;
            state_d   = S_ADDR;
          end
          S_ADDR: if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
`ifdef SPI_FLASH_FAST_READ_EN
            state_d   = S_DUMMY;
`else
            state_d   = S_DATA;
`endif
          end
`ifdef SPI_FLASH_FAST_READ_EN
          S_DUMMY: if (bit_cnt_q == 6'd7) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end
`endif
          S_DATA: begin
            rx_d = {rx_q[5:0], bus.i_spi_miso};
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d  = '0;
              wstb_d     = 1'b1;
              wdata_d    = {rx_q, bus.i_spi_miso};
              waddr_d    = byte_cnt_q[BRAM_AW-1:0];
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
              if (byte_cnt_q == len_q - LEN_W'(1)) state_d = S_END;
            end
          end
          default: ;
        endcase
      end
    end else begin
      // unreachable encoding: drop the bus and recover to idle
      state_d = S_IDLE;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b1;
      mosi_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sclk_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wstb_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wstb_q     <= wstb_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
    end
  end

  assign bus.o_busy            = busy_q;
  assign bus.o_read_done_stb   = done_q;
  assign bus.o_write_bram_stb  = wstb_q;
  assign bus.o_write_bram_addr = waddr_q;
  assign bus.o_write_bram_data = wdata_q;
  assign bus.o_spi_cs_n        = cs_n_q;
  assign bus.o_spi_clk         = sclk_q;
  assign bus.o_spi_mosi        = mosi_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench for spi_flash_reader. Two instances
// (3-byte and 4-byte addressing, SPI_CLK_DIV=2) share a behavioural flash
// model through a select mux; requests are issued from one initial block.
module tb_spi_flash_reader;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int FAST = 1;
  localparam logic [7:0] OP3 = 8'h0B;
  localparam logic [7:0] OP4 = 8'h0C;
`else
  localparam int FAST = 0;
  localparam logic [7:0] OP3 = 8'h03;
  localparam logic [7:0] OP4 = 8'h13;
`endif
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;          // 0: 3-byte instance, 1: 4-byte instance
  logic        stb = 1'b0;
  logic [31:0] addr = '0;
  logic [10:0] len = '0;
  logic        miso = 1'b1;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_reader_if #(.BRAM_AW(10)) ifa ();
  spi_flash_reader_if #(.BRAM_AW(10)) ifb ();

  spi_flash_reader #(.BLOCK_SIZE(512), .BRAM_AW(10), .ADDR_BYTES(3), .SPI_CLK_DIV(DIV))
    dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  spi_flash_reader #(.BLOCK_SIZE(512), .BRAM_AW(10), .ADDR_BYTES(4), .SPI_CLK_DIV(DIV))
    dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  assign ifa.i_read_addr = addr;
  assign ifb.i_read_addr = addr;
  assign ifa.i_read_len  = len;
  assign ifb.i_read_len  = len;
  assign ifa.i_read_stb  = stb & ~sel;
  assign ifb.i_read_stb  = stb & sel;
  assign ifa.i_spi_miso  = miso;
  assign ifb.i_spi_miso  = miso;

  wire       cs_n  = sel ? ifb.o_spi_cs_n       : ifa.o_spi_cs_n;
  wire       sclk  = sel ? ifb.o_spi_clk        : ifa.o_spi_clk;
  wire       mosi  = sel ? ifb.o_spi_mosi       : ifa.o_spi_mosi;
  wire       busy  = sel ? ifb.o_busy           : ifa.o_busy;
  wire       done  = sel ? ifb.o_read_done_stb  : ifa.o_read_done_stb;
  wire       wstb  = sel ? ifb.o_write_bram_stb : ifa.o_write_bram_stb;
  wire [9:0] waddr = sel ? ifb.o_write_bram_addr : ifa.o_write_bram_addr;
  wire [7:0] wdata = sel ? ifb.o_write_bram_data : ifa.o_write_bram_data;

  // flash contents and model state
  logic [7:0]  fmem [512];
  int          hdr = 32;            // SPI clocks before the first data bit
  int          fall_cnt = 0, rise_cnt = 0, dummy_ones = 0;
  logic [39:0] mosi_cap = '0;
  int          nbytes = 0, bad_bytes = 0, last_idx = -1, done_total = 0;
  int          checks = 0, failures = 0;
  int          t0 = 0, d_cyc = 0;

  // flash drives the next data bit after each falling edge
  always @(negedge sclk) begin
    if (!cs_n) begin
      int j;
      j = fall_cnt - hdr;
      if (j >= 0 && j < 4096) miso = fmem[j / 8][7 - (j % 8)];
      fall_cnt = fall_cnt + 1;
    end
  end

  // capture opcode/address and dummy bits on rising edges
  always @(posedge sclk) begin
    if (!cs_n) begin
      if (rise_cnt < (sel ? 40 : 32)) mosi_cap = {mosi_cap[38:0], mosi};
      else if (rise_cnt < hdr) dummy_ones = dummy_ones + int'(mosi);
      rise_cnt = rise_cnt + 1;
    end
  end

  // BRAM write scoreboard and done counter
  always @(negedge clk) begin
    if (wstb) begin
      if (waddr !== 10'(nbytes) || wdata !== fmem[nbytes[8:0]]) bad_bytes = bad_bytes + 1;
      last_idx = int'(waddr);
      nbytes = nbytes + 1;
    end
    if (done) done_total = done_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe in the cycle after the next falling clk edge; returns mid-cycle
  // of the first busy cycle. cs_pre is CS as seen in the strobe cycle.
  task automatic start_req(input logic s, input logic [31:0] a, input logic [10:0] l,
                           output logic cs_pre);
    @(negedge clk);
    cs_pre = cs_n;
    sel = s; addr = a; len = l;
    nbytes = 0; bad_bytes = 0; last_idx = -1;
    fall_cnt = 0; rise_cnt = 0; dummy_ones = 0; mosi_cap = '0;
    hdr = 8 + (s ? 32 : 24) + 8 * FAST;
    t0 = cyc;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check("busy_after_stb", busy, 1);
    check("cs_after_stb", cs_n, 0);
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        d_cyc = cyc;
      end
    end
    check("done_within_budget", ok, 1);
  endtask

  // request/response checks once the done pulse has been seen
  task automatic finish_checks(input string tag, input int elen);
    int n, lat;
    logic [39:0] exp_hdr;
    n   = 8 + (sel ? 32 : 24) + 8 * FAST + 8 * elen;
    lat = 2 * DIV * n + DIV + 2;      // counted strobe cycle .. done cycle inclusive
    exp_hdr = sel ? {OP4, addr} : {8'h00, OP3, addr[23:0]};
    check({tag, "_latency"}, d_cyc - t0 + 1, lat);
    check({tag, "_nbytes"}, nbytes, elen);
    check({tag, "_bad_bytes"}, bad_bytes, 0);
    check({tag, "_last_idx"}, last_idx, elen - 1);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_cs_at_done"}, cs_n, 1);
    check({tag, "_mosi_hdr"}, mosi_cap, exp_hdr);
    if (FAST != 0) check({tag, "_dummy_ones"}, dummy_ones, 8);
    $display("txn %s sel=%0d addr=%08h len=%0d bytes=%0d latency=%0d", tag, sel, addr,
             elen, nbytes, d_cyc - t0 + 1);
  endtask

  initial begin
    logic cs_pre;
    logic found;
    for (int i = 0; i < 512; i++) fmem[i] = 8'(i * 37 + 11);
    fmem[0] = 8'hA5; fmem[1] = 8'h5A; fmem[2] = 8'hFF; fmem[3] = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_mosi", mosi, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wstb", wstb, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);

    // 3-byte read, 4 bytes
    start_req(1'b0, 32'h0001_2345, 11'd4, cs_pre);
    wait_done();
    finish_checks("rd3_len4", 4);

    // back-to-back: strobe in the cycle after done
    start_req(1'b0, 32'h0000_0100, 11'd2, cs_pre);
    check("b2b_cs_high_gap", cs_pre, 1);
    wait_done();
    finish_checks("rd3_b2b_len2", 2);

    // 4-byte addressing, single byte
    start_req(1'b1, 32'hDEAD_BEEF, 11'd1, cs_pre);
    wait_done();
    finish_checks("rd4_len1", 1);

    // reset while shifting the address with SPI clock low
    start_req(1'b0, 32'h00AB_CDEF, 11'd8, cs_pre);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (rise_cnt >= 14 && sclk == 1'b0) found = 1'b1;
    end
    check("reached_addr_phase", found, 1);
    rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 1);
    check("midrst_mosi", mosi, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_total, 3);
    start_req(1'b0, 32'h0001_2345, 11'd3, cs_pre);
    wait_done();
    finish_checks("rd3_after_rst", 3);

    // len 0 means a full block; a strobe mid-transfer is ignored
    start_req(1'b0, 32'h0000_0000, 11'd0, cs_pre);
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (nbytes >= 100) found = 1'b1;
    end
    check("reached_byte_100", found, 1);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    wait_done();
    finish_checks("rd3_len0_block", 512);
    repeat (20) @(negedge clk);
    check("ignored_stb_busy", busy, 0);
    check("ignored_stb_cs", cs_n, 1);
    check("ignored_stb_nbytes", nbytes, 512);
    check("done_total", done_total, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
